// File: rtl/round_score_tracker_pkg.sv
// Shared definitions for the best-of-9 scoreboard.
// The finish detector and the display logic use the same result codes,
// winner codes and state encodings.
//   RES_*  : round result codes offered on the result input
//   WIN_*  : winner codes reported by the finish detector
//   ST_*   : tracker state encodings (2-bit, legacy-compatible constants)
//   add_one: 4-bit incrementer built as a half-adder carry chain
package round_score_tracker_pkg;

    localparam logic [1:0] RES_BAD  = 2'b00;
    localparam logic [1:0] RES_DRAW = 2'b01;
    localparam logic [1:0] RES_P1   = 2'b10;
    localparam logic [1:0] RES_P2   = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_TIE  = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_P2   = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_CHECK = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    // Ripple half-adder chain: bit i toggles when all lower bits are 1.
    function automatic logic [3:0] add_one(input logic [3:0] a);
        logic [3:0] s;
        s[0] = ~a[0];
        s[1] = a[1] ^ a[0];
        s[2] = a[2] ^ (a[1] & a[0]);
        s[3] = a[3] ^ (a[2] & a[1] & a[0]);
        return s;
    endfunction

endpackage

// File: rtl/round_score_tracker_counter.sv
// score_counter: 4-bit count register with synchronous clear and increment
// enable. Clear wins over increment.
//   clk, reset_n : clock and asynchronous active-low reset
//   clear        : zero the count on the next edge
//   inc          : add one on the next edge
//   count        : registered count
module score_counter
    import round_score_tracker_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] count
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (inc) begin
            count <= add_one(count);
        end
    end

endmodule

// File: rtl/round_score_tracker.sv
// round_score_tracker: accepts one round result per handshake, keeps the
// round/win/lose counts, waits one settle cycle for the downstream finish
// detector, then either reopens for the next result or freezes the game and
// latches the winner.
//   clk, reset_n   : clock, asynchronous active-low reset
//   start          : clear counts/winner and begin a new game (top priority)
//   result_valid   : result offered this cycle
//   result         : 10 P1 wins, 11 P2 wins, 01 draw, 00 illegal
//   result_ready   : tracker accepts a result this cycle
//   fin            : finish flag from the detector, settled during CHECK
//   printwinner    : detector winner code, latched on game end
//   round/win/lose : registered counts
//   game_over      : game frozen
//   final_winner   : latched winner, 00 until a game ends
//   err_illegal    : one-cycle pulse after an accepted 00 result
module round_score_tracker
    import round_score_tracker_pkg::*;
#(
    parameter int unsigned MAX_ROUNDS = 9
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       result_valid,
    input  logic [1:0] result,
    output logic       result_ready,
    input  logic       fin,
    input  logic [1:0] printwinner,
    output logic [3:0] round,
    output logic [3:0] win,
    output logic [3:0] lose,
    output logic       game_over,
    output logic [1:0] final_winner,
    output logic       err_illegal
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       transfer;
    logic       legal;
    logic       illegal;
    logic       end_game;

    assign result_ready = (state == ST_PLAY);
    assign game_over    = (state == ST_OVER);

    // start drops any result offered in the same cycle.
    assign transfer = result_valid && result_ready && !start;
    assign legal    = transfer && (result != RES_BAD);
    assign illegal  = transfer && (result == RES_BAD);

    // Counts are stable through CHECK, so fin/printwinner have settled.
    assign end_game = (state == ST_CHECK) && !start &&
                      (fin || (round == 4'(MAX_ROUNDS)));

    // NOTE: the default assignment before the case keeps this block purely
    // combinational; a missing branch would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_PLAY;
        end else begin
            case (state)
                ST_PLAY:  if (legal) state_next = ST_CHECK;
                ST_CHECK: state_next = end_game ? ST_OVER : ST_PLAY;
                default:  state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            final_winner <= WIN_NONE;
            err_illegal  <= 1'b0;
        end else begin
            state       <= state_next;
            err_illegal <= illegal;
            if (start) begin
                final_winner <= WIN_NONE;
            end else if (end_game) begin
                final_winner <= printwinner;
            end
        end
    end

    score_counter u_round (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start),
        .inc     (legal),
        .count   (round)
    );

    score_counter u_win (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start),
        .inc     (legal && (result == RES_P1)),
        .count   (win)
    );

    score_counter u_lose (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start),
        .inc     (legal && (result == RES_P2)),
        .count   (lose)
    );

endmodule

// File: tb/tb_round_score_tracker.sv
// Bench for round_score_tracker: a behavioural game model plus a stand-in
// finish detector (first to 5 round wins), a per-cycle compare on the falling
// edge, and literal expectations after each directed scenario.
module tb_round_score_tracker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       result_valid = 1'b0;
    logic [1:0] result = 2'b00;
    logic       result_ready;
    logic       fin;
    logic [1:0] printwinner;
    logic [3:0] round;
    logic [3:0] win;
    logic [3:0] lose;
    logic       game_over;
    logic [1:0] final_winner;
    logic       err_illegal;

    int tests_run = 0;
    int tests_failed = 0;

    round_score_tracker #(.MAX_ROUNDS(9)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .result_valid (result_valid),
        .result       (result),
        .result_ready (result_ready),
        .fin          (fin),
        .printwinner  (printwinner),
        .round        (round),
        .win          (win),
        .lose         (lose),
        .game_over    (game_over),
        .final_winner (final_winner),
        .err_illegal  (err_illegal)
    );

    always #5 clk = ~clk;

    // Downstream finish detector: a player with 5 round wins takes the game.
    function automatic logic det_fin(input logic [3:0] w, input logic [3:0] l);
        return (w >= 4'd5) || (l >= 4'd5);
    endfunction

    function automatic logic [1:0] det_winner(input logic [3:0] w, input logic [3:0] l);
        if (w > l) return 2'b10;
        if (l > w) return 2'b11;
        return 2'b01;
    endfunction

    assign fin         = det_fin(win, lose);
    assign printwinner = det_winner(win, lose);

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of one game, in terms of the game rules.
    typedef enum {G_IDLE, G_ACCEPTING, G_SETTLING, G_FINISHED} game_phase_t;
    game_phase_t m_phase;
    logic [3:0]  m_round, m_win, m_lose;
    logic [1:0]  m_winner;
    logic        m_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase  <= G_IDLE;
            m_round  <= 4'd0;
            m_win    <= 4'd0;
            m_lose   <= 4'd0;
            m_winner <= 2'b00;
            m_err    <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (start) begin
                m_phase  <= G_ACCEPTING;
                m_round  <= 4'd0;
                m_win    <= 4'd0;
                m_lose   <= 4'd0;
                m_winner <= 2'b00;
            end else begin
                case (m_phase)
                    G_ACCEPTING: if (result_valid) begin
                        if (result == 2'b00) begin
                            m_err <= 1'b1;
                        end else begin
                            m_round <= m_round + 4'd1;
                            if (result == 2'b10) m_win  <= m_win + 4'd1;
                            if (result == 2'b11) m_lose <= m_lose + 4'd1;
                            m_phase <= G_SETTLING;
                        end
                    end
                    G_SETTLING: begin
                        if (det_fin(m_win, m_lose) || m_round == 4'd9) begin
                            m_winner <= det_winner(m_win, m_lose);
                            m_phase  <= G_FINISHED;
                        end else begin
                            m_phase <= G_ACCEPTING;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("ready",     {3'b0, result_ready}, {3'b0, m_phase == G_ACCEPTING});
        check("round",     round, m_round);
        check("win",       win, m_win);
        check("lose",      lose, m_lose);
        check("game_over", {3'b0, game_over}, {3'b0, m_phase == G_FINISHED});
        check("winner",    {2'b0, final_winner}, {2'b0, m_winner});
        check("err",       {3'b0, err_illegal}, {3'b0, m_err});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Offer one result for a cycle, then idle through the settle cycle.
    task automatic play_round(input logic [1:0] res);
        result_valid = 1'b1;
        result       = res;
        step();
        result_valid = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12 reset_n = 1'b1;
        step();
        step();
        check("lit_reset_ready", {3'b0, result_ready}, 4'd0);
        check("lit_reset_round", round, 4'd0);

        // P1 wins 5 straight: detector finishes the game.
        pulse_start();
        for (int i = 0; i < 5; i++) play_round(2'b10);
        check("lit_t1_round",  round, 4'd5);
        check("lit_t1_win",    win, 4'd5);
        check("lit_t1_lose",   lose, 4'd0);
        check("lit_t1_winner", {2'b0, final_winner}, 4'b0010);
        check("lit_t1_over",   {3'b0, game_over}, 4'd1);
        step();
        check("lit_t1_frozen", round, 4'd5);

        // Nine draws: round cap finishes the game as a tie.
        pulse_start();
        for (int i = 0; i < 9; i++) play_round(2'b01);
        check("lit_t2_round",  round, 4'd9);
        check("lit_t2_win",    win, 4'd0);
        check("lit_t2_lose",   lose, 4'd0);
        check("lit_t2_winner", {2'b0, final_winner}, 4'b0001);
        check("lit_t2_ready",  {3'b0, result_ready}, 4'd0);

        // Illegal code: one-cycle error pulse, no settle cycle.
        pulse_start();
        check("lit_t3_ready0", {3'b0, result_ready}, 4'd1);
        result_valid = 1'b1;
        result       = 2'b00;
        step();
        result_valid = 1'b0;
        check("lit_t3_err1",   {3'b0, err_illegal}, 4'd1);
        check("lit_t3_ready1", {3'b0, result_ready}, 4'd1);
        check("lit_t3_round",  round, 4'd0);
        step();
        check("lit_t3_err2",   {3'b0, err_illegal}, 4'd0);
        check("lit_t3_ready2", {3'b0, result_ready}, 4'd1);

        // Valid held high: accept every other cycle.
        result_valid = 1'b1;
        result       = 2'b10;
        for (int i = 0; i < 6; i++) begin
            check("lit_t4_ready", {3'b0, result_ready}, {3'b0, (i % 2) == 0});
            step();
        end
        result_valid = 1'b0;
        check("lit_t4_win",   win, 4'd3);
        check("lit_t4_round", round, 4'd3);

        // start during PLAY with a result offered: result dropped.
        start        = 1'b1;
        result_valid = 1'b1;
        result       = 2'b10;
        step();
        start        = 1'b0;
        result_valid = 1'b0;
        check("lit_t5_round", round, 4'd0);
        check("lit_t5_win",   win, 4'd0);
        check("lit_t5_ready", {3'b0, result_ready}, 4'd1);
        check("lit_t5_over",  {3'b0, game_over}, 4'd0);

        // Reset during CHECK after the third round.
        play_round(2'b10);
        play_round(2'b11);
        result_valid = 1'b1;
        result       = 2'b01;
        step();
        result_valid = 1'b0;
        check("lit_t6_pre_round", round, 4'd3);
        check("lit_t6_pre_ready", {3'b0, result_ready}, 4'd0);
        reset_n = 1'b0;
        #1;
        check("lit_t6_round", round, 4'd0);
        check("lit_t6_win",   win, 4'd0);
        check("lit_t6_lose",  lose, 4'd0);
        check("lit_t6_ready", {3'b0, result_ready}, 4'd0);
        check("lit_t6_over",  {3'b0, game_over}, 4'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("lit_t6_idle", {3'b0, result_ready}, 4'd0);
        play_round(2'b10);
        check("lit_t6_nostart", round, 4'd0);
        pulse_start();
        play_round(2'b10);
        check("lit_t6_restart", win, 4'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
